match_controller: RTL and testbench

Parametrised best-of-N match sequencer that replaces the single-round hold-to-reset timer and winner latch in the student top level. It consumes both players' health values and the 20 Hz game tick, and runs a round countdown, fight, pause, round-over and match-over sequence. It drives a play-enable gate to the movement and physics blocks, a round-restart pulse to the health and physics blocks, per-player round scores, and the winner code consumed by the menu.

---
 rtl/match_pkg.sv | 40 ++++
 rtl/hold_detector.sv | 54 +++++
 rtl/match_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_match_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared state encoding, winner codes and score helpers for the match sequencer
//
// Contents:
//   state_t        : FSM state encoding (COUNTDOWN=0, FIGHT=1, PAUSED=2, ROUND_OVER=3, MATCH_OVER=4)
//   WIN_*          : 2-bit winner codes used by round_winner / match_winner
//   score_inc()    : saturating increment for 3-bit round scores
//   higher_score() : winner code for the higher of two scores, draw when equal

package match_pkg;

    typedef enum logic [2:0] {
        ST_COUNTDOWN  = 3'd0,
        ST_FIGHT      = 3'd1,
        ST_PAUSED     = 3'd2,
        ST_ROUND_OVER = 3'd3,
        ST_MATCH_OVER = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [2:0] SCORE_MAX = 3'd7;

    // Scores stop at 7 rather than wrapping back to 0.
    function automatic logic [2:0] score_inc(input logic [2:0] s);
        return (s == SCORE_MAX) ? s : s + 3'd1;
    endfunction

    function automatic logic [1:0] higher_score(input logic [2:0] a, input logic [2:0] b);
        if (a > b)
            return WIN_P1;
        else if (b > a)
            return WIN_P2;
        else
            return WIN_DRAW;
    endfunction

endpackage

// File: rtl/hold_detector.sv
// rtl/hold_detector.sv - synchronised, tick-counted "button held" detector
//
// Ports:
//   i_clk, i_reset : system clock, asynchronous active-high reset
//   i_tick         : game-rate strobe; the hold counter advances only on it
//   i_raw          : raw asynchronous button/switch level
//   i_clear        : restart the count and ignore the input until it is released
//   o_held         : high while the counter sits at HOLD_TICKS

module hold_detector #(
    parameter int HOLD_TICKS = 40
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_raw,
    input  logic i_clear,
    output logic o_held
);

    localparam int CNT_W = $clog2(HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_TICKS);

    logic             r_sync_1;
    logic             r_sync_2;
    logic             r_blocked;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync_1  <= 1'b0;
            r_sync_2  <= 1'b0;
            r_blocked <= 1'b0;
            r_count   <= '0;
        end else begin
            r_sync_1 <= i_raw;
            r_sync_2 <= r_sync_1;
            if (i_clear) begin
                // After an action fires, the same continuous press must not
                // fire it again: stay blocked until the input is seen low.
                r_count   <= '0;
                r_blocked <= 1'b1;
            end else if (!r_sync_2) begin
                r_count   <= '0;
                r_blocked <= 1'b0;
            end else if (i_tick && !r_blocked && (r_count != HOLD_MAX)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_held = (r_count == HOLD_MAX);

endmodule

// File: rtl/match_controller.sv
// rtl/match_controller.sv - best-of-N match sequencer: countdown, fight, pause, round-over, match-over
//
// Ports:
//   i_clk, i_reset            : system clock, asynchronous active-high reset
//   i_tick                    : one-cycle game-rate strobe
//   i_health_1, i_health_2    : player health, 0 = knocked out
//   i_confirm_btn             : held in MATCH_OVER to start a new match
//   i_pause_btn               : rising edge toggles pause during a fight
//   i_force_reset             : held in any state to restart the match
//   o_state                   : current state (match_pkg encoding)
//   o_play_enable             : high only while fighting
//   o_round_reset             : one-cycle pulse on the first COUNTDOWN cycle of a new round
//   o_round_winner            : winner of the last round (WIN_* code)
//   o_match_winner            : match result, non-zero only in MATCH_OVER
//   o_score_1, o_score_2      : rounds won per player
//   o_countdown               : ticks left before the fight starts

module match_controller
    import match_pkg::*;
#(
    parameter int HP_W            = 9,
    parameter int ROUNDS_TO_WIN   = 2,
    parameter int MAX_ROUNDS      = 5,
    parameter int COUNTDOWN_TICKS = 60,
    parameter int GAP_TICKS       = 40,
    parameter int HOLD_TICKS      = 40,
    localparam int CD_W           = $clog2(COUNTDOWN_TICKS + 1)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_tick,
    input  logic [HP_W-1:0] i_health_1,
    input  logic [HP_W-1:0] i_health_2,
    input  logic            i_confirm_btn,
    input  logic            i_pause_btn,
    input  logic            i_force_reset,
    output logic [2:0]      o_state,
    output logic            o_play_enable,
    output logic            o_round_reset,
    output logic [1:0]      o_round_winner,
    output logic [1:0]      o_match_winner,
    output logic [2:0]      o_score_1,
    output logic [2:0]      o_score_2,
    output logic [CD_W-1:0] o_countdown
);

    localparam int GAP_W = $clog2(GAP_TICKS + 1);
    localparam int RC_W  = $clog2(MAX_ROUNDS + 1);

    localparam logic [CD_W-1:0]  CD_RELOAD = CD_W'(COUNTDOWN_TICKS);
    localparam logic [CD_W-1:0]  CD_ONE    = CD_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TICKS - 1);
    localparam logic [RC_W-1:0]  RC_MAX    = RC_W'(MAX_ROUNDS);
    localparam logic [2:0]       RTW       = 3'(ROUNDS_TO_WIN);

    state_t           r_state;
    logic [CD_W-1:0]  r_countdown;
    logic [GAP_W-1:0] r_gap;
    logic [RC_W-1:0]  r_round_cnt;
    logic [2:0]       r_score_1;
    logic [2:0]       r_score_2;
    logic [1:0]       r_round_winner;
    logic [1:0]       r_match_winner;
    logic             r_play_enable;
    logic             r_round_reset;

    logic r_pause_s1;
    logic r_pause_s2;
    logic r_pause_prev;

    logic w_pause_edge;
    logic w_confirm_held;
    logic w_force_held;
    logic w_new_match;
    logic w_ko_1;
    logic w_ko_2;
    logic w_match_decided;

    // Both detectors are cleared on any restart so a single press can
    // never trigger two back-to-back new matches.
    hold_detector #(.HOLD_TICKS(HOLD_TICKS)) u_confirm_hold (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_tick  (i_tick),
        .i_raw   (i_confirm_btn),
        .i_clear (w_new_match),
        .o_held  (w_confirm_held)
    );

    hold_detector #(.HOLD_TICKS(HOLD_TICKS)) u_force_hold (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_tick  (i_tick),
        .i_raw   (i_force_reset),
        .i_clear (w_new_match),
        .o_held  (w_force_held)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pause_s1   <= 1'b0;
            r_pause_s2   <= 1'b0;
            r_pause_prev <= 1'b0;
        end else begin
            r_pause_s1   <= i_pause_btn;
            r_pause_s2   <= r_pause_s1;
            r_pause_prev <= r_pause_s2;
        end
    end

    assign w_pause_edge    = r_pause_s2 & ~r_pause_prev;
    assign w_new_match     = w_force_held | ((r_state == ST_MATCH_OVER) & w_confirm_held);
    assign w_ko_1          = (i_health_1 == '0);
    assign w_ko_2          = (i_health_2 == '0);
    assign w_match_decided = (r_score_1 >= RTW) | (r_score_2 >= RTW) | (r_round_cnt >= RC_MAX);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_COUNTDOWN;
            r_countdown    <= CD_RELOAD;
            r_gap          <= '0;
            r_round_cnt    <= '0;
            r_score_1      <= 3'd0;
            r_score_2      <= 3'd0;
            r_round_winner <= WIN_NONE;
            r_match_winner <= WIN_NONE;
            r_play_enable  <= 1'b0;
            r_round_reset  <= 1'b0;
        end else begin
            r_round_reset <= 1'b0;
            if (w_new_match) begin
                r_state        <= ST_COUNTDOWN;
                r_countdown    <= CD_RELOAD;
                r_gap          <= '0;
                r_round_cnt    <= '0;
                r_score_1      <= 3'd0;
                r_score_2      <= 3'd0;
                r_round_winner <= WIN_NONE;
                r_match_winner <= WIN_NONE;
                r_play_enable  <= 1'b0;
                r_round_reset  <= 1'b1;
            end else begin
                case (r_state)
                    ST_COUNTDOWN: begin
                        if (i_tick) begin
                            if (r_countdown <= CD_ONE) begin
                                r_state       <= ST_FIGHT;
                                r_countdown   <= '0;
                                r_play_enable <= 1'b1;
                            end else begin
                                r_countdown <= r_countdown - 1'b1;
                            end
                        end
                    end

                    ST_FIGHT: begin
                        // A knockout takes priority over a pause edge in the same cycle.
                        if (w_ko_1 || w_ko_2) begin
                            r_state       <= ST_ROUND_OVER;
                            r_play_enable <= 1'b0;
                            r_gap         <= '0;
                            r_round_cnt   <= r_round_cnt + 1'b1;
                            if (w_ko_1 && w_ko_2) begin
                                r_round_winner <= WIN_DRAW;
                            end else if (w_ko_2) begin
                                r_round_winner <= WIN_P1;
                                r_score_1      <= score_inc(r_score_1);
                            end else begin
                                r_round_winner <= WIN_P2;
                                r_score_2      <= score_inc(r_score_2);
                            end
                        end else if (w_pause_edge) begin
                            r_state       <= ST_PAUSED;
                            r_play_enable <= 1'b0;
                        end
                    end

                    ST_PAUSED: begin
                        if (w_pause_edge) begin
                            r_state       <= ST_FIGHT;
                            r_play_enable <= 1'b1;
                        end
                    end

                    ST_ROUND_OVER: begin
                        if (i_tick) begin
                            if (r_gap == GAP_LAST) begin
                                r_gap <= '0;
                                if (w_match_decided) begin
                                    r_state        <= ST_MATCH_OVER;
                                    r_match_winner <= higher_score(r_score_1, r_score_2);
                                end else begin
                                    r_state        <= ST_COUNTDOWN;
                                    r_countdown    <= CD_RELOAD;
                                    r_round_winner <= WIN_NONE;
                                    r_round_reset  <= 1'b1;
                                end
                            end else begin
                                r_gap <= r_gap + 1'b1;
                            end
                        end
                    end

                    ST_MATCH_OVER: begin
                        // Leaves only through w_new_match.
                    end

                    default: begin
                        r_state       <= ST_COUNTDOWN;
                        r_countdown   <= CD_RELOAD;
                        r_play_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_state        = r_state;
    assign o_play_enable  = r_play_enable;
    assign o_round_reset  = r_round_reset;
    assign o_round_winner = r_round_winner;
    assign o_match_winner = r_match_winner;
    assign o_score_1      = r_score_1;
    assign o_score_2      = r_score_2;
    assign o_countdown    = r_countdown;

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - self-checking bench for match_controller

module tb_match_controller;
    import match_pkg::*;

    localparam int HP_W  = 9;
    localparam int RTW   = 2;
    localparam int MAXR  = 5;
    localparam int CD    = 60;
    localparam int GAP   = 40;
    localparam int HOLD  = 40;
    localparam int CD_W  = $clog2(CD + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            tick = 1'b0;
    logic [HP_W-1:0] health_1 = 9'd100;
    logic [HP_W-1:0] health_2 = 9'd100;
    logic            confirm_btn = 1'b0;
    logic            pause_btn = 1'b0;
    logic            force_reset = 1'b0;
    logic [2:0]      state;
    logic            play_enable;
    logic            round_reset;
    logic [1:0]      round_winner;
    logic [1:0]      match_winner;
    logic [2:0]      score_1;
    logic [2:0]      score_2;
    logic [CD_W-1:0] countdown;

    int n_tests = 0;
    int n_fail  = 0;
    int rr_seen = 0;
    int rr_bad  = 0;
    int pe_bad  = 0;
    int exp_rr  = 0;
    logic rr_prev = 1'b0;

    int m_s1 = 0;
    int m_s2 = 0;
    int m_rounds = 0;

    always #5 clk = ~clk;

    match_controller #(
        .HP_W(HP_W), .ROUNDS_TO_WIN(RTW), .MAX_ROUNDS(MAXR),
        .COUNTDOWN_TICKS(CD), .GAP_TICKS(GAP), .HOLD_TICKS(HOLD)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_tick(tick),
        .i_health_1(health_1), .i_health_2(health_2),
        .i_confirm_btn(confirm_btn), .i_pause_btn(pause_btn), .i_force_reset(force_reset),
        .o_state(state), .o_play_enable(play_enable), .o_round_reset(round_reset),
        .o_round_winner(round_winner), .o_match_winner(match_winner),
        .o_score_1(score_1), .o_score_2(score_2), .o_countdown(countdown)
    );

    // Continuous properties: round_reset is single-cycle and only in COUNTDOWN,
    // play_enable tracks FIGHT exactly.
    always @(negedge clk) begin
        if (round_reset === 1'b1) begin
            rr_seen++;
            if (state !== 3'd0 || rr_prev === 1'b1) rr_bad++;
        end
        rr_prev = round_reset;
        if (play_enable !== (state == 3'd1)) pe_bad++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_tick();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick();
    endtask

    function automatic int model_match_winner();
        if (m_s1 > m_s2) return 1;
        if (m_s2 > m_s1) return 2;
        return 3;
    endfunction

    task automatic run_countdown();
        check("cd_start_state", state, 3'd0);
        check("cd_start_value", countdown, CD);
        do_tick();
        check("cd_first_tick", countdown, CD - 1);
        ticks(CD - 2);
        check("cd_last_value", countdown, 1);
        check("cd_still_counting", state, 3'd0);
        do_tick();
        check("cd_to_fight_state", state, 3'd1);
        check("cd_to_fight_value", countdown, 0);
        check("cd_play_enable", play_enable, 1);
    endtask

    task automatic gap_and_decide(input bit run_cd, output bit over);
        ticks(GAP - 1);
        check("gap_hold_state", state, 3'd3);
        do_tick();
        over = (m_s1 >= RTW) || (m_s2 >= RTW) || (m_rounds >= MAXR);
        if (over) begin
            check("match_over_state", state, 3'd4);
            check("match_winner", match_winner, model_match_winner());
            check("match_over_no_rr", round_reset, 0);
        end else begin
            check("next_round_state", state, 3'd0);
            check("next_round_rr", round_reset, 1);
            check("next_round_winner_clr", round_winner, 0);
            check("next_round_cd", countdown, CD);
            exp_rr++;
            step();
            check("next_round_rr_width", round_reset, 0);
            if (run_cd) run_countdown();
        end
    endtask

    task automatic play_round(input int h1, input int h2, input bit run_cd, output bit over);
        int w;
        repeat ($urandom_range(0, 3)) step();
        health_1 = HP_W'(h1);
        health_2 = HP_W'(h2);
        step();
        if (h1 == 0 && h2 == 0) w = 3;
        else if (h2 == 0) w = 1;
        else w = 2;
        if (w == 1) m_s1 = (m_s1 < 7) ? m_s1 + 1 : 7;
        if (w == 2) m_s2 = (m_s2 < 7) ? m_s2 + 1 : 7;
        m_rounds++;
        check("ko_state", state, 3'd3);
        check("ko_round_winner", round_winner, w);
        check("ko_score_1", score_1, m_s1);
        check("ko_score_2", score_2, m_s2);
        check("ko_play_enable", play_enable, 0);
        health_1 = 9'd100;
        health_2 = 9'd100;
        gap_and_decide(run_cd, over);
    endtask

    task automatic restart_confirm();
        confirm_btn = 1'b1;
        repeat (3) step();
        ticks(HOLD - 1);
        check("confirm_39_state", state, 3'd4);
        do_tick();
        step();
        check("confirm_restart_state", state, 3'd0);
        check("confirm_restart_rr", round_reset, 1);
        check("confirm_restart_s1", score_1, 0);
        check("confirm_restart_s2", score_2, 0);
        check("confirm_restart_mw", match_winner, 0);
        check("confirm_restart_rw", round_winner, 0);
        check("confirm_restart_cd", countdown, CD);
        exp_rr++;
        m_s1 = 0; m_s2 = 0; m_rounds = 0;
        confirm_btn = 1'b0;
        step();
        check("confirm_rr_width", round_reset, 0);
        run_countdown();
    endtask

    initial begin
        bit over;
        int r;
        int hv;

        #1 reset = 1'b1;
        step();
        step();
        check("rst_state", state, 3'd0);
        check("rst_countdown", countdown, CD);
        check("rst_play_enable", play_enable, 0);
        check("rst_round_reset", round_reset, 0);
        check("rst_score_1", score_1, 0);
        check("rst_score_2", score_2, 0);
        check("rst_round_winner", round_winner, 0);
        check("rst_match_winner", match_winner, 0);
        reset = 1'b0;
        step();
        run_countdown();
        check("no_rr_after_reset", rr_seen, 0);

        // Match 1: P1 takes two straight rounds, then confirm-hold restart.
        play_round(100, 0, 1'b1, over);
        play_round(200, 0, 1'b1, over);
        restart_confirm();

        // Match 2: pause behaviour, then force_reset while paused at 1:1.
        play_round(150, 0, 1'b1, over);
        pause_btn = 1'b1;
        repeat (3) step();
        check("pause_state", state, 3'd2);
        check("pause_play_enable", play_enable, 0);
        health_1 = 9'd0;
        repeat (5) step();
        check("pause_ignores_ko", state, 3'd2);
        check("pause_score_2", score_2, 0);
        pause_btn = 1'b0;
        repeat (3) step();
        pause_btn = 1'b1;
        repeat (3) step();
        check("unpause_state", state, 3'd1);
        check("unpause_play_enable", play_enable, 1);
        step();
        m_s2 = 1;
        m_rounds = 2;
        check("unpause_ko_state", state, 3'd3);
        check("unpause_ko_winner", round_winner, 2);
        check("unpause_ko_score_2", score_2, 1);
        health_1 = 9'd100;
        pause_btn = 1'b0;
        gap_and_decide(1'b1, over);
        pause_btn = 1'b1;
        repeat (3) step();
        check("pause2_state", state, 3'd2);
        force_reset = 1'b1;
        repeat (3) step();
        ticks(HOLD - 1);
        check("force_39_state", state, 3'd2);
        check("force_39_score_1", score_1, 1);
        do_tick();
        step();
        check("force_state", state, 3'd0);
        check("force_rr", round_reset, 1);
        check("force_score_1", score_1, 0);
        check("force_score_2", score_2, 0);
        check("force_cd", countdown, CD);
        exp_rr++;
        m_s1 = 0; m_s2 = 0; m_rounds = 0;
        force_reset = 1'b0;
        pause_btn = 1'b0;
        step();
        run_countdown();

        // Match 3: five draws end the match on the round limit as a draw.
        repeat (MAXR) play_round(0, 0, 1'b1, over);
        check("draw_match_score_1", score_1, 0);
        restart_confirm();

        // Randomised matches against the score model.
        repeat (3) begin
            over = 1'b0;
            while (!over) begin
                r  = int'($urandom_range(0, 2));
                hv = int'($urandom_range(1, 511));
                case (r)
                    0:       play_round(hv, 0, 1'b1, over);
                    1:       play_round(0, hv, 1'b1, over);
                    default: play_round(0, 0, 1'b1, over);
                endcase
            end
            restart_confirm();
        end

        // Asynchronous reset in the middle of a countdown with a non-zero score.
        play_round(100, 0, 1'b0, over);
        ticks(10);
        check("pre_async_cd", countdown, CD - 10);
        check("pre_async_score_1", score_1, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_cd", countdown, CD);
        check("async_state", state, 3'd0);
        check("async_score_1", score_1, 0);
        step();
        reset = 1'b0;
        step();

        check("rr_pulse_shape", rr_bad, 0);
        check("play_enable_tracks_fight", pe_bad, 0);
        check("rr_pulse_count", rr_seen, exp_rr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
